// File: rtl/sobel_3x3_kernel_module.sv
// Pipelined 3x3 Sobel filter: vertical/horizontal gradient, magnitude or bypass per pixel.
// Window sampled at edge N is presented on the outputs at edge N+3.
module sobel_3x3_kernel_module #(
    parameter int unsigned CH_W     = 4,
    parameter int unsigned NCH      = 3,
    parameter int unsigned SHIFT    = 0,
    parameter bit          ABS_GRAD = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [9*NCH*CH_W-1:0]   window_data,
    input  logic [1:0]              mode,
    output logic                    out_valid,
    output logic [NCH*CH_W-1:0]     filter_out,
    output logic [NCH*CH_W-1:0]     centre_out
);
    localparam int unsigned PW = NCH * CH_W;
    localparam int unsigned GW = CH_W + 4;
    localparam logic [GW-1:0] ChMax = GW'((1 << CH_W) - 1);

    localparam int unsigned SlotC  = 0;
    localparam int unsigned SlotL  = 1;
    localparam int unsigned SlotR  = 2;
    localparam int unsigned SlotU  = 3;
    localparam int unsigned SlotD  = 4;
    localparam int unsigned SlotUl = 5;
    localparam int unsigned SlotUr = 6;
    localparam int unsigned SlotDl = 7;
    localparam int unsigned SlotDr = 8;

    typedef enum logic [1:0] {
        ModeKv     = 2'd0,
        ModeKh     = 2'd1,
        ModeMag    = 2'd2,
        ModeBypass = 2'd3
    } mode_e;

    // Slot 0 (centre) sits in the window MSBs.
    function automatic logic [CH_W-1:0] px_ch(input logic [9*PW-1:0] win,
                                              input int unsigned slot,
                                              input int unsigned ch);
        return win[(8 - slot) * PW + ch * CH_W +: CH_W];
    endfunction

    function automatic logic signed [GW-1:0] ext(input logic [CH_W-1:0] v);
        return $signed({4'b0000, v});
    endfunction

    // Stage 1: input capture
    logic [9*PW-1:0] r1_win;
    mode_e           r1_mode;
    logic            r1_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r1_valid <= 1'b0;
        end else begin
            r1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        r1_win  <= window_data;
        r1_mode <= mode_e'(mode);
    end

    // Stage 2: signed gradients and their magnitudes
    logic [GW-1:0]  w_abs_kv [NCH];
    logic [GW-1:0]  w_abs_kh [NCH];
    logic [GW-1:0]  w_mag    [NCH];
    logic [NCH-1:0] w_kv_neg;
    logic [NCH-1:0] w_kh_neg;

    for (genvar c = 0; c < NCH; c++) begin : g_grad
        logic signed [GW-1:0] w_kv;
        logic signed [GW-1:0] w_kh;

        assign w_kv = (ext(px_ch(r1_win, SlotDl, c)) + (ext(px_ch(r1_win, SlotD, c)) <<< 1)
                       + ext(px_ch(r1_win, SlotDr, c)))
                    - (ext(px_ch(r1_win, SlotUl, c)) + (ext(px_ch(r1_win, SlotU, c)) <<< 1)
                       + ext(px_ch(r1_win, SlotUr, c)));
        assign w_kh = (ext(px_ch(r1_win, SlotUr, c)) + (ext(px_ch(r1_win, SlotR, c)) <<< 1)
                       + ext(px_ch(r1_win, SlotDr, c)))
                    - (ext(px_ch(r1_win, SlotUl, c)) + (ext(px_ch(r1_win, SlotL, c)) <<< 1)
                       + ext(px_ch(r1_win, SlotDl, c)));

        assign w_kv_neg[c] = w_kv[GW-1];
        assign w_kh_neg[c] = w_kh[GW-1];
        assign w_abs_kv[c] = w_kv[GW-1] ? -w_kv : w_kv;
        assign w_abs_kh[c] = w_kh[GW-1] ? -w_kh : w_kh;
        assign w_mag[c]    = w_abs_kv[c] + w_abs_kh[c];
    end

    logic [GW-1:0]  r2_abs_kv [NCH];
    logic [GW-1:0]  r2_abs_kh [NCH];
    logic [GW-1:0]  r2_mag    [NCH];
    logic [NCH-1:0] r2_kv_neg;
    logic [NCH-1:0] r2_kh_neg;
    logic [PW-1:0]  r2_centre;
    mode_e          r2_mode;
    logic           r2_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r2_valid <= 1'b0;
        end else begin
            r2_valid <= r1_valid;
        end
    end

    always_ff @(posedge clk) begin
        r2_abs_kv <= w_abs_kv;
        r2_abs_kh <= w_abs_kh;
        r2_mag    <= w_mag;
        r2_kv_neg <= w_kv_neg;
        r2_kh_neg <= w_kh_neg;
        r2_centre <= r1_win[9*PW-1 -: PW];
        r2_mode   <= r1_mode;
    end

    // Stage 3: mode select, shift and per-channel saturation
    logic [PW-1:0] w_res;

    for (genvar c = 0; c < NCH; c++) begin : g_sat
        logic [GW-1:0] w_g;
        logic [GW-1:0] w_r;

        always_comb begin
            case (r2_mode)
                ModeKv:  w_g = (r2_kv_neg[c] && !ABS_GRAD) ? '0 : r2_abs_kv[c];
                ModeKh:  w_g = (r2_kh_neg[c] && !ABS_GRAD) ? '0 : r2_abs_kh[c];
                default: w_g = r2_mag[c];
            endcase
        end

        assign w_r = w_g >> SHIFT;
        assign w_res[c*CH_W +: CH_W] = (r2_mode == ModeBypass) ? r2_centre[c*CH_W +: CH_W]
                                     : (w_r > ChMax)           ? ChMax[CH_W-1:0]
                                     :                           w_r[CH_W-1:0];
    end

    logic [PW-1:0] r3_res;
    logic [PW-1:0] r3_centre;
    logic          r3_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r3_valid <= 1'b0;
        end else begin
            r3_valid <= r2_valid;
        end
    end

    always_ff @(posedge clk) begin
        r3_res    <= w_res;
        r3_centre <= r2_centre;
    end

    // Output register holds the last result across bubbles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            filter_out <= '0;
            centre_out <= '0;
        end else begin
            out_valid <= r3_valid;
            if (r3_valid) begin
                filter_out <= r3_res;
                centre_out <= r3_centre;
            end
        end
    end

endmodule

// File: tb/tb_sobel_3x3_kernel_module.sv
// Directed bench for the Sobel filter; three instances cover SHIFT and ABS_GRAD variants.
module tb_sobel_3x3_kernel_module;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [107:0] window_data;
    logic [1:0]   mode;

    logic        v0, va, vs;
    logic [11:0] f0, fa, fs;
    logic [11:0] c0, ca, cs;

    always #5 clk = ~clk;

    sobel_3x3_kernel_module #(.CH_W(4), .NCH(3), .SHIFT(0), .ABS_GRAD(1'b0)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .window_data(window_data), .mode(mode),
        .out_valid(v0), .filter_out(f0), .centre_out(c0)
    );

    sobel_3x3_kernel_module #(.CH_W(4), .NCH(3), .SHIFT(0), .ABS_GRAD(1'b1)) u_abs (
        .clk(clk), .reset(reset), .in_valid(in_valid), .window_data(window_data), .mode(mode),
        .out_valid(va), .filter_out(fa), .centre_out(ca)
    );

    sobel_3x3_kernel_module #(.CH_W(4), .NCH(3), .SHIFT(1), .ABS_GRAD(1'b0)) u_sh (
        .clk(clk), .reset(reset), .in_valid(in_valid), .window_data(window_data), .mode(mode),
        .out_valid(vs), .filter_out(fs), .centre_out(cs)
    );

    typedef struct {
        logic [11:0] f0;
        logic [11:0] fa;
        logic [11:0] fs;
        logic [11:0] c;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    bit          mon_en = 1'b0;
    logic [11:0] last_f0 = '0, last_fa = '0, last_fs = '0, last_c = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%03h expected 0x%03h (cycle %0d)", tag, obs, expv, cyc);
    endtask

    // Integer reference of the filter arithmetic for one parameter set.
    function automatic logic [11:0] model(input logic [107:0] win, input logic [1:0] md,
                                          input int sh, input bit ab);
        logic [11:0] res;
        int p[9];
        int kv, kh, akv, akh, g;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < 9; s++) p[s] = int'(win[(8 - s) * 12 + c * 4 +: 4]);
            kv  = p[7] + 2 * p[4] + p[8] - p[5] - 2 * p[3] - p[6];
            kh  = p[6] + 2 * p[2] + p[8] - p[5] - 2 * p[1] - p[7];
            akv = (kv < 0) ? -kv : kv;
            akh = (kh < 0) ? -kh : kh;
            case (md)
                2'd0:    g = ab ? akv : ((kv < 0) ? 0 : kv);
                2'd1:    g = ab ? akh : ((kh < 0) ? 0 : kh);
                default: g = akv + akh;
            endcase
            g = g >>> sh;
            if (g > 15) g = 15;
            res[c * 4 +: 4] = (md == 2'd3) ? win[96 + c * 4 +: 4] : 4'(g);
        end
        return res;
    endfunction

    function automatic logic [107:0] mk(input logic [11:0] c, l, r, u, d, ul, ur, dl, dr);
        return {c, l, r, u, d, ul, ur, dl, dr};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [107:0] win, input logic [1:0] md);
        exp_t e;
        in_valid    = 1'b1;
        window_data = win;
        mode        = md;
        e.f0  = model(win, md, 0, 1'b0);
        e.fa  = model(win, md, 0, 1'b1);
        e.fs  = model(win, md, 1, 1'b0);
        e.c   = win[107:96];
        e.due = cyc + 4;
        sb.push_back(e);
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    // Scoreboard: every negedge the valid flag must match the queue head's due cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        bit   exp_v;
        if (mon_en) begin
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            check("out_valid", 12'(v0), 12'(exp_v));
            check("out_valid_abs", 12'(va), 12'(exp_v));
            check("out_valid_shift", 12'(vs), 12'(exp_v));
            if (exp_v) begin
                e = sb.pop_front();
                check("filter_out", f0, e.f0);
                check("filter_out_abs", fa, e.fa);
                check("filter_out_shift", fs, e.fs);
                check("centre_out", c0, e.c);
                check("centre_out_shift", cs, e.c);
                last_f0 = e.f0;
                last_fa = e.fa;
                last_fs = e.fs;
                last_c  = e.c;
            end else begin
                check("hold_filter", f0, last_f0);
                check("hold_filter_abs", fa, last_fa);
                check("hold_centre", c0, last_c);
            end
            if (reset === 1'b0) begin
                sb.delete();
                last_f0 = '0;
                last_fa = '0;
                last_fs = '0;
                last_c  = '0;
            end
        end
    end

    initial begin
        logic [127:0] rnd;
        reset       = 1'b0;
        in_valid    = 1'b0;
        window_data = '0;
        mode        = 2'd0;
        repeat (2) step();
        check("reset_out_valid", 12'(v0), 12'd0);
        check("reset_filter_out", f0, 12'h000);
        check("reset_centre_out", c0, 12'h000);
        check("reset_out_valid_abs", 12'(va), 12'd0);
        check("reset_out_valid_shift", 12'(vs), 12'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Uniform window: zero gradient, centre passes through
        send(mk(12'hAAA, 12'hAAA, 12'hAAA, 12'hAAA, 12'hAAA, 12'hAAA, 12'hAAA, 12'hAAA,
                12'hAAA), 2'd0);
        idle(4);

        // Horizontal edges, rising, saturating and falling
        send(mk(12'h555, 12'h555, 12'h555, 12'h000, 12'h222, 12'h000, 12'h000, 12'h222,
                12'h222), 2'd0);
        send(mk(12'h555, 12'h555, 12'h555, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF,
                12'hFFF), 2'd0);
        send(mk(12'h555, 12'h555, 12'h555, 12'h222, 12'h000, 12'h222, 12'h222, 12'h000,
                12'h000), 2'd0);
        // Unused slots changed: KV ignores centre/left/right, KH ignores up/down
        send(mk(12'hF0F, 12'hABC, 12'h123, 12'h000, 12'h222, 12'h000, 12'h000, 12'h222,
                12'h222), 2'd0);
        send(mk(12'h9E1, 12'h000, 12'h333, 12'hC4D, 12'h7B2, 12'h000, 12'h111, 12'h000,
                12'h111), 2'd1);
        idle(4);

        // Magnitude mode
        send(mk(12'h111, 12'h000, 12'h111, 12'h000, 12'h111, 12'h000, 12'h000, 12'h111,
                12'h111), 2'd2);
        idle(4);

        // Streaming with a bubble after the fourth window, modes cycling
        for (int i = 0; i < 10; i++) begin
            if (i == 4) idle(1);
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(rnd[107:0], 2'(i % 4));
        end
        idle(4);

        // Reset with three pixels in flight
        for (int i = 0; i < 3; i++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(rnd[107:0], 2'(i));
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        idle(5);

        // Per-channel independence: red +60, green -60, blue 0
        send(mk(12'h123, 12'h456, 12'h789, 12'h0F5, 12'hF05, 12'h0F5, 12'h0F5, 12'hF05,
                12'hF05), 2'd0);
        idle(6);

        check("scoreboard_empty", 12'(sb.size()), 12'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
